// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and register address type for the multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  function automatic int addr_w(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  localparam int AW_DEF = addr_w(NREG_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy vector: dispatch sets, write-back clears, set beats clear, x0 never busy.
// Latency: updates on the clock edge after the request; backpressure: none, every request is absorbed.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = addr_w(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic            bset,
  input  logic [AW-1:0]   bsa,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy;
    for (int r = 1; r < NREG; r++) begin
      if ((we0 && wa0 == AW'(r)) || (we1 && wa1 == AW'(r))) busy_d[r] = 1'b0;
      // A new producer supersedes the one retiring this cycle.
      if (bset && bsa == AW'(r)) busy_d[r] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_d;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file (2 write, NRP read) with x0 hard-wired to zero and a busy scoreboard.
// Latency: combinational reads, writes on the rising edge; REGFILE_MP_BYPASS_EN forwards same-cycle writes. No backpressure.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRP  = 2,
  localparam int AW  = addr_w(NREG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NRP-1:0][AW-1:0]   ra,
  output logic [NRP-1:0][XLEN-1:0] rd,
  output logic [NRP-1:0]           rbusy,
  input  logic                     we0,
  input  logic [AW-1:0]            wa0,
  input  logic [XLEN-1:0]          wd0,
  input  logic                     we1,
  input  logic [AW-1:0]            wa1,
  input  logic [XLEN-1:0]          wd1,
  input  logic                     bset,
  input  logic [AW-1:0]            bsa,
  output logic [NREG-1:0]          busy
);

  logic [XLEN-1:0] regs [NREG];

  rf_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
    .clk  (clk),
    .rst  (rst),
    .we0  (we0),
    .wa0  (wa0),
    .we1  (we1),
    .wa1  (wa1),
    .bset (bset),
    .bsa  (bsa),
    .busy (busy)
  );

  // Port 1 is written last so it wins a same-address dual write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      if (we0 && wa0 != '0) regs[wa0] <= wd0;
      if (we1 && wa1 != '0) regs[wa1] <= wd1;
    end
  end

  always_comb begin
    for (int i = 0; i < NRP; i++) begin
      rd[i]    = '0;
      rbusy[i] = 1'b0;
      if (ra[i] != '0) begin
        rd[i]    = regs[ra[i]];
        rbusy[i] = busy[ra[i]];
`ifdef REGFILE_MP_BYPASS_EN
        if (!rst) begin
          if (we1 && wa1 == ra[i])      rd[i] = wd1;
          else if (we0 && wa0 == ra[i]) rd[i] = wd0;
          if (((we0 && wa0 == ra[i]) || (we1 && wa1 == ra[i])) && !(bset && bsa == ra[i]))
            rbusy[i] = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, architectural register count; power of two, minimum 2.
REQ-003 SHALL have parameter NRP, default 2, number of read ports; range 1 to 4.
REQ-004 SHALL derive local parameter AW = clog2(NREG).
REQ-005 SHALL have ports as follows:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ra  in  NRP x AW  read addresses.
- rd  out  NRP x XLEN  read data.
- rbusy  out  NRP  per-read-port busy flag.
- we0/wa0/wd0  in  1/AW/XLEN  write port 0 (ALU commit).
- we1/wa1/wd1  in  1/AW/XLEN  write port 1 (load commit).
- bset/bsa  in  1/AW  scoreboard set request and address (dispatch).
- busy  out  NREG  full scoreboard vector.

Function
REQ-006 SHALL make register 0 read as zero on every port, ignore writes to it and never mark it busy.
REQ-007 SHALL make reads combinational; rd[i] reflects regs[ra[i]] in the same cycle.
REQ-008 SHALL perform writes on the rising edge of clk when weN is high and waN is not zero.
REQ-009 SHALL give port 1 priority on a same-address dual write (we0 = we1 = 1, wa0 = wa1): wd1 is stored and wd0 is dropped.
REQ-010 SHALL set busy[bsa] on the clock edge when bset is high and bsa is not zero.
REQ-011 SHALL clear busy[waN] on the clock edge when weN is high and waN is not zero.
REQ-012 SHALL let a set win over a clear when both target the same address in the same cycle, because a new producer supersedes the old one.
REQ-013 SHALL make rbusy[i] equal busy[ra[i]] combinationally, and 0 when ra[i] is zero.
REQ-014 SHALL leave register contents and busy bits unchanged when no enable is active.

Reset
REQ-015 SHALL, while rst is high and independent of clk, clear all registers to 0 and all busy bits to 0.
REQ-016 SHALL, when rst asserts mid-operation, discard any write or set in that cycle; first updates occur on the first clk edge after rst deasserts.
REQ-017 SHALL drive rd to 0 and rbusy to 0 during reset, since all state is zero.

Configuration
REQ-018 SHALL use macro REGFILE_MP_BYPASS_EN.
REQ-019 SHALL, with the macro defined, forward same-cycle write data: rd[i] = wd1 if we1 and wa1 == ra[i] (nonzero), else wd0 if we0 and wa0 == ra[i], else the stored value. rbusy[i] SHALL read 0 when a write matches ra[i] in that cycle, unless bset also targets ra[i].
REQ-020 SHALL, without the macro, return stored values only; written data is visible the cycle after the write edge and rbusy reflects registered busy only.

Structure
REQ-021 SHALL place the XLEN/NREG defaults, the AW derivation function and a typedef reg_addr_t in shared package regfile_pkg.
REQ-022 SHALL implement one sub-module, rf_scoreboard, holding the busy vector and REQ-010 to REQ-012; the storage array and read muxing stay in regfile_mp.

Verification
REQ-023 Reset and zero: assert rst mid-run after writing 0xDEADBEEF to x5 -> rd of x5 = 0 immediately, busy = 0; write 0x1234 to x0 -> x0 reads 0.
REQ-024 Dual-write conflict: we0 = we1 = 1, wa = 7, wd0 = 0xAAAA, wd1 = 0x5555 -> next cycle x7 = 0x5555.
REQ-025 Scoreboard: bset with bsa = 3 -> busy[3] = 1 next cycle and rbusy = 1 on ra = 3; we0 to x3 -> busy[3] = 0; bset plus we1 on x3 in the same cycle -> busy[3] stays 1.
REQ-026 Bypass with macro: we1 to x9 with 0xCAFE, ra[0] = 9 in the same cycle -> rd[0] = 0xCAFE combinationally. Without macro -> old value that cycle, 0xCAFE the next.
REQ-027 Parameter sweep: XLEN = 64, NREG = 16, NRP = 4; write all-ones to x15, read it on all 4 ports -> each rd = 0xFFFF_FFFF_FFFF_FFFF; bsa = 0 with bset -> busy stays 0.
